hazard_stall_controller: RTL and testbench

- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Detects load-use hazards between the ID stage and the ID/EX stage.
- Flushes IF/ID on taken branches and jumps.
- Holds the front end while the multi-cycle mult/div unit (MDU) runs, and freezes the whole pipeline on a data-memory wait.
- Drives the PC write enable, the IF/ID write enable and flush, the ID/EX bubble (control zeroing) and the later-stage hold, and keeps a stall-cycle performance counter.

---
 rtl/hazard_stall_controller.sv | 132 +++++++++++++
 tb/tb_hazard_stall_controller.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock,
// branch/jump flush, MDU front-end hold and data-memory freeze, plus a
// saturating stall-cycle performance counter.
module hazard_stall_controller #(
    parameter int MDU_LATENCY = 32,
    parameter int PERF_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_uses_rt,
    input  logic              id_ex_mem_read,
    input  logic [4:0]        id_ex_rt,
    input  logic              branch_taken,
    input  logic              jump,
    input  logic              mdu_start,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              pipe_hold,
    output logic              mdu_busy,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam int CNT_W = $clog2(MDU_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] mdu_cnt;
    logic [CNT_W-1:0] mdu_cnt_next;
    logic             freeze;
    logic             load_use;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] value);
        if (value == '1) begin
            return value;
        end
        return value + PERF_W'(1);
    endfunction

    assign freeze   = mem_req & ~mem_ready;
    // Register 0 is never a real producer, so a load to $zero cannot hazard.
    assign load_use = id_ex_mem_read & (id_ex_rt != 5'd0) &
                      ((id_ex_rt == id_rs) | (id_uses_rt & (id_ex_rt == id_rt)));
    assign mdu_busy = (state == MDU_BUSY);

    // Next-state/counter logic and the zero-latency pipeline controls.
    always_comb begin
        state_next   = state;
        mdu_cnt_next = mdu_cnt;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_hold    = 1'b0;

        // The MDU runs on its own, so the countdown continues while frozen.
        case (state)
            RUN: begin
                if (!freeze && mdu_start) begin
                    state_next   = MDU_BUSY;
                    mdu_cnt_next = CNT_LOAD;
                end
            end
            MDU_BUSY: begin
                if (mdu_cnt <= CNT_ONE) begin
                    state_next   = RUN;
                    mdu_cnt_next = '0;
                end else begin
                    mdu_cnt_next = mdu_cnt - CNT_ONE;
                end
            end
            default: begin
                state_next   = RUN;
                mdu_cnt_next = '0;
            end
        endcase

        if (!reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            pipe_hold    = 1'b1;
        end else if (state == MDU_BUSY) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (mdu_start) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
        end else if (load_use) begin
            // Stall wins over a branch: it re-resolves next cycle with forwarded data.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (branch_taken || jump) begin
            if_id_flush  = 1'b1;
        end
    end

    // State, MDU countdown and stall-cycle counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= RUN;
            mdu_cnt      <= '0;
            stall_cycles <= '0;
        end else begin
            state   <= state_next;
            mdu_cnt <= mdu_cnt_next;
            if (!pc_write) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Randomized and directed bench for hazard_stall_controller against a
// cycle-level reference model of the stall/flush rules.
module tb_hazard_stall_controller;

    localparam int LAT = 4;
    localparam int PW  = 4;
    localparam int SAT = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    id_rs, id_rt, id_ex_rt;
    logic          id_uses_rt, id_ex_mem_read, branch_taken, jump;
    logic          mdu_start, mem_req, mem_ready;
    logic          pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, mdu_busy;
    logic [PW-1:0] stall_cycles;

    int tests = 0;
    int fails = 0;

    // Reference model state: cycles of front-end hold still owed, and stall total.
    int       m_busy_left;
    int       m_stalls;
    logic [4:0] e_ctl;   // {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold}
    int       n_pc_low;
    int       n_busy;

    hazard_stall_controller #(.MDU_LATENCY(LAT), .PERF_W(PW)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
        .branch_taken(branch_taken), .jump(jump), .mdu_start(mdu_start),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .pipe_hold(pipe_hold), .mdu_busy(mdu_busy),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic quiet();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_ex_mem_read = 1'b0;
        id_ex_rt = 5'd0; branch_taken = 1'b0; jump = 1'b0; mdu_start = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic randomize_inputs(input bit allow_reset);
        id_rs          = 5'($urandom_range(0, 3));
        id_rt          = 5'($urandom_range(0, 3));
        id_ex_rt       = 5'($urandom_range(0, 3));
        id_uses_rt     = 1'($urandom_range(0, 1));
        id_ex_mem_read = 1'($urandom_range(0, 1));
        branch_taken   = ($urandom_range(0, 3) == 0);
        jump           = ($urandom_range(0, 7) == 0);
        mdu_start      = ($urandom_range(0, 7) == 0);
        mem_req        = ($urandom_range(0, 3) == 0);
        mem_ready      = 1'($urandom_range(0, 1));
        reset          = allow_reset ? ($urandom_range(0, 63) != 0) : 1'b1;
    endtask

    // One clock: check the combinational controls mid-cycle, then advance the model.
    task automatic cycle();
        logic frz;
        logic lu;
        #2;
        frz = mem_req & ~mem_ready;
        lu  = id_ex_mem_read && (id_ex_rt != 0) &&
              ((id_ex_rt == id_rs) || (id_uses_rt && (id_ex_rt == id_rt)));
        if (!reset)                    e_ctl = 5'b00110;
        else if (frz)                  e_ctl = 5'b00001;
        else if (m_busy_left > 0)      e_ctl = 5'b00010;
        else if (mdu_start)            e_ctl = 5'b11000;
        else if (lu)                   e_ctl = 5'b00010;
        else if (branch_taken || jump) e_ctl = 5'b11100;
        else                           e_ctl = 5'b11000;
        check("controls", 32'({pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold}), 32'(e_ctl));
        check("mdu_busy", 32'(mdu_busy), 32'(m_busy_left > 0));
        check("stall_cycles", 32'(stall_cycles), 32'(m_stalls));
        if (!pc_write) n_pc_low++;
        if (mdu_busy)  n_busy++;
        @(posedge clk);
        if (!reset) begin
            m_busy_left = 0;
            m_stalls    = 0;
        end else begin
            if (!e_ctl[4]) m_stalls = (m_stalls < SAT) ? m_stalls + 1 : SAT;
            if (m_busy_left > 0)          m_busy_left = m_busy_left - 1;
            else if (!frz && mdu_start)   m_busy_left = LAT - 1;
        end
        #1;
    endtask

    task automatic do_reset();
        quiet();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
    endtask

    initial begin
        quiet();
        reset = 1'b0;
        @(posedge clk);
        #1;
        m_busy_left = 0;
        m_stalls    = 0;
        n_pc_low    = 0;
        n_busy      = 0;

        // Reset held two cycles under random inputs, then release with quiet inputs.
        for (int i = 0; i < 2; i++) begin
            randomize_inputs(1'b0);
            reset = 1'b0;
            cycle();
        end
        quiet();
        reset = 1'b1;
        cycle();
        check("post_reset_stalls", 32'(stall_cycles), 32'd0);

        // Load-use on rs.
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd5; id_rs = 5'd5;
        cycle();
        quiet();
        cycle();
        check("load_use_stalls", 32'(stall_cycles), 32'd1);

        // Load to $zero never stalls.
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd0; id_rs = 5'd0;
        cycle();
        // rt match without rt use never stalls.
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b0;
        cycle();
        quiet();
        cycle();
        check("no_stall_cases", 32'(stall_cycles), 32'd1);

        // Branch alone flushes; branch with load-use stalls without flush.
        branch_taken = 1'b1;
        cycle();
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd7; id_rs = 5'd7;
        cycle();
        quiet();
        cycle();

        // MDU sequence with branch during busy.
        do_reset();
        mdu_start = 1'b1;
        cycle();
        mdu_start = 1'b0;
        branch_taken = 1'b1;
        n_pc_low = 0; n_busy = 0;
        for (int i = 0; i < 4; i++) cycle();
        check("mdu_pc_low_cycles", 32'(n_pc_low), 32'(LAT - 1));
        check("mdu_busy_cycles", 32'(n_busy), 32'(LAT - 1));
        quiet();

        // Memory freeze in the middle of MDU busy; exit timing unchanged.
        mdu_start = 1'b1;
        cycle();
        mdu_start = 1'b0;
        n_busy = 0;
        cycle();
        mem_req = 1'b1; mem_ready = 1'b0;
        cycle();
        cycle();
        quiet();
        cycle();
        cycle();
        check("mdu_busy_frozen", 32'(n_busy), 32'(LAT - 1));

        // Reset in the middle of an MDU sequence aborts it.
        mdu_start = 1'b1;
        cycle();
        quiet();
        cycle();
        do_reset();
        cycle();
        check("mdu_abort", 32'(mdu_busy), 32'd0);

        // Saturation of the stall counter.
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd9; id_rs = 5'd9;
        for (int i = 0; i < 20; i++) cycle();
        quiet();
        cycle();
        check("stall_saturate", 32'(stall_cycles), 32'(SAT));

        // Randomized traffic, including occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs(1'b1);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
